// File: rtl/rotary_value_counter_pkg.sv
// Shared types and constants for the rotary value counter slice.
package rotary_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  typedef enum logic [1:0] {
    SLOW   = 2'd0,
    ARMING = 2'd1,
    FAST   = 2'd2
  } accel_state_t;

endpackage

// File: rtl/rotary_value_counter_gap_timer.sv
// Saturating gap timer: counts cycles since the last restart and flags
// whether the next event would arrive inside the fast window.
module rotary_gap_timer #(
  parameter int unsigned WINDOW = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic saturate,
  output logic fast,
  output logic expired
);

  localparam int TW = (WINDOW < 2) ? 1 : $clog2(WINDOW + 1);
  localparam logic [TW-1:0] LIMIT = TW'(WINDOW);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (saturate) begin
      count_d = LIMIT;
    end else if (restart) begin
      count_d = '0;
    end else if (count_q != LIMIT) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= LIMIT;
    end else begin
      count_q <= count_d;
    end
  end

  assign fast    = (count_q != LIMIT);
  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/rotary_value_counter.sv
// Up/down value counter driven by rotary cw/ccw pulses, with wrap or saturate.
// Speed-dependent acceleration is built only when ROTARY_VALUE_ACCEL_EN is defined.
module rotary_value_counter
  import rotary_pkg::*;
#(
  parameter int          WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned INIT        = 0,
  parameter bit          WRAP        = 1'b1,
  parameter int unsigned STEP_FAST   = 4,
  parameter int unsigned FAST_WINDOW = 2500000,
  parameter int unsigned FAST_COUNT  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rotary_cw,
  input  logic             rotary_ccw,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             changed,
  output logic             last_dir,
  output logic             accel_active
);

  localparam logic [WIDTH-1:0] INIT_V   = WIDTH'(INIT);
  localparam logic [WIDTH:0]   STEP_ONE = (WIDTH+1)'(1);

  logic [WIDTH-1:0] value_q, value_d;
  logic             changed_q, changed_d;
  logic             last_dir_q, last_dir_d;

  // cw and ccw together is not an event at all; clear also swallows any event.
  logic ev_valid, ev_dir, accept;
  assign ev_valid = rotary_cw ^ rotary_ccw;
  assign ev_dir   = rotary_cw ? DIR_CW : DIR_CCW;
  assign accept   = ev_valid & ~clear;

  logic [WIDTH:0]   step, ext, sum, diff;
  logic [WIDTH-1:0] next_val;

`ifdef ROTARY_VALUE_ACCEL_EN
  localparam int SW = (FAST_COUNT < 2) ? 1 : $clog2(FAST_COUNT + 1);
  localparam logic [SW-1:0]  STREAK_ARM = SW'(FAST_COUNT - 1);
  localparam logic [WIDTH:0] STEP_BIG   = (WIDTH+1)'(STEP_FAST);

  accel_state_t  state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          accel_q, accel_d;
  logic          ev_fast, gap_expired;
  logic          same_dir;

  rotary_gap_timer #(
    .WINDOW (FAST_WINDOW)
  ) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (accept),
    .saturate (clear),
    .fast     (ev_fast),
    .expired  (gap_expired)
  );

  assign same_dir = (ev_dir == last_dir_q);

  // A reversing event always moves by one, even out of FAST.
  assign step = (state_q == FAST && same_dir) ? STEP_BIG : STEP_ONE;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    if (clear) begin
      state_d  = SLOW;
      streak_d = '0;
    end else if (accept) begin
      case (state_q)
        SLOW: begin
          state_d  = ARMING;
          streak_d = SW'(1);
        end
        ARMING: begin
          if (!same_dir || !ev_fast) begin
            streak_d = SW'(1);
          end else if (streak_q == STREAK_ARM) begin
            state_d  = FAST;
            streak_d = streak_q + 1'b1;
          end else begin
            streak_d = streak_q + 1'b1;
          end
        end
        FAST: begin
          if (!same_dir || !ev_fast) begin
            state_d  = ARMING;
            streak_d = SW'(1);
          end
        end
        default: begin
          state_d  = SLOW;
          streak_d = '0;
        end
      endcase
    end else if (gap_expired && state_q != SLOW) begin
      state_d  = SLOW;
      streak_d = '0;
    end
    accel_d = (state_d == FAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SLOW;
      streak_q <= '0;
      accel_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      accel_q  <= accel_d;
    end
  end

  assign accel_active = accel_q;
`else
  assign step         = STEP_ONE;
  assign accel_active = 1'b0;
`endif

  // One extra bit carries the overflow/borrow used for saturation.
  always_comb begin
    ext  = {1'b0, value_q};
    sum  = ext + step;
    diff = ext - step;
    if (WRAP) begin
      next_val = ev_dir ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
    end else if (ev_dir) begin
      next_val = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end else begin
      next_val = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
    end
  end

  always_comb begin
    value_d    = value_q;
    changed_d  = 1'b0;
    last_dir_d = last_dir_q;
    if (clear) begin
      value_d   = INIT_V;
      changed_d = (value_q != INIT_V);
    end else if (accept) begin
      value_d    = next_val;
      changed_d  = (next_val != value_q);
      last_dir_d = ev_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q    <= INIT_V;
      changed_q  <= 1'b0;
      last_dir_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      changed_q  <= changed_d;
      last_dir_q <= last_dir_d;
    end
  end

  assign value    = value_q;
  assign changed  = changed_q;
  assign last_dir = last_dir_q;

endmodule
